alu_muldiv_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide controller that reuses the shared 32-bit combinational ALU for its iterative add/subtract steps instead of instantiating its own adder. It sits beside the ALU in the execute stage and borrows the ALU only while busy. It accepts a start/op request, runs 32 shift-add (MULTU) or restoring-subtract (DIVU) iterations, and returns a 64-bit result as hi/lo with a one-cycle done pulse.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_muldiv_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared between the 32-bit execute-stage ALU and the blocks that
// borrow it (currently alu_muldiv_sequencer).
//   - ALU control codes (ALU_control input of the ALU)
//   - ALU status bit indices (ALU_status output of the ALU)
//   - Multiply/divide sequencer state encoding and sizing
// -----------------------------------------------------------------------------
package alu_pkg;

    // Datapath width of the shared ALU.
    localparam int ALU_WIDTH = 32;

    // ALU control codes.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU status bit indices.
    localparam int STATUS_ZERO            = 7;
    localparam int STATUS_OVERFLOW        = 6;
    localparam int STATUS_CARRY           = 5;
    localparam int STATUS_NEGATIVE        = 4;
    localparam int STATUS_INVALID_ADDRESS = 3;
    localparam int STATUS_DIV_ZERO        = 2;

    // Sequencer operation select.
    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    // One iteration per bit of the 32-bit operand.
    localparam int          SEQ_ITERATIONS = ALU_WIDTH;
    localparam int          SEQ_COUNT_W    = $clog2(SEQ_ITERATIONS);
    localparam logic [SEQ_COUNT_W-1:0] SEQ_LAST_COUNT = SEQ_COUNT_W'(SEQ_ITERATIONS - 1);

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_MUL  = 2'b01,
        SEQ_DIV  = 2'b10,
        SEQ_DONE = 2'b11
    } seq_state_t;

    // Result loaded for an unsigned divide by zero: remainder = dividend,
    // quotient = all ones.
    function automatic logic [2*ALU_WIDTH-1:0] div_by_zero_result(
        input logic [ALU_WIDTH-1:0] dividend
    );
        return {dividend, {ALU_WIDTH{1'b1}}};
    endfunction

endpackage : alu_pkg

// File: rtl/alu_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// alu_muldiv_sequencer
// Multi-cycle unsigned multiply (MULTU) / divide (DIVU) controller. It does not
// own an adder: every add/subtract step is issued to the shared combinational
// ALU in the execute stage, and the ALU result/carry are folded back into the
// hi/lo accumulator at the same clock edge.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   start          in   request, sampled only in IDLE
//   op             in   0 = MULTU, 1 = DIVU
//   operand_a      in   [31:0] multiplicand / dividend
//   operand_b      in   [31:0] multiplier / divisor
//   busy           out  high whenever not IDLE
//   done           out  one-cycle pulse, hi/lo valid
//   hi             out  [31:0] product[63:32] / remainder
//   lo             out  [31:0] product[31:0]  / quotient
//   div_zero       out  last DIVU had divisor 0, held until next start
//   alu_control    out  [3:0]  to ALU_control
//   alu_operand_1  out  [31:0] to ALU_operand_1
//   alu_operand_2  out  [31:0] to ALU_operand_2
//   alu_result     in   [31:0] from ALU_result
//   alu_status     in   [7:0]  from ALU_status (only the carry bit is used)
//
// Latency: start accepted at edge ending cycle N -> done in N+33 (N+1 for a
// divide by zero), IDLE again the cycle after done.
// -----------------------------------------------------------------------------
module alu_muldiv_sequencer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_operand_1,
    output logic [31:0] alu_operand_2,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status
);

    seq_state_t             state_reg,    state_next;
    logic [SEQ_COUNT_W-1:0] count_reg,    count_next;
    logic [31:0]            hi_reg,       hi_next;
    logic [31:0]            lo_reg,       lo_next;
    logic [31:0]            mcand_reg,    mcand_next;
    logic [31:0]            divisor_reg,  divisor_next;
    logic                   div_zero_reg, div_zero_next;

    logic        alu_carry;
    logic [31:0] div_shifted;   // partial remainder shifted left by one
    logic        div_msb;       // bit shifted out of hi (33rd remainder bit)
    logic        div_q;         // quotient bit of this step

    // Only the carry/borrow flag matters here; the other flags describe the
    // ALU result in ways this sequencer never needs.
    logic unused_status;
    assign unused_status = ^{alu_status[7:6], alu_status[4:0]};

    assign alu_carry   = alu_status[STATUS_CARRY];
    assign div_shifted = {hi_reg[30:0], lo_reg[31]};
    assign div_msb     = hi_reg[31];
    // When the shifted-out bit is set, the 33-bit partial remainder is at
    // least 2^32 and therefore larger than any divisor, so the subtraction
    // must be taken regardless of the ALU borrow. The 32-bit ALU difference is
    // still exact because the true difference is below 2^32.
    assign div_q       = div_msb | ~alu_carry;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= SEQ_IDLE;
            count_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            mcand_reg    <= '0;
            divisor_reg  <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            mcand_reg    <= mcand_next;
            divisor_reg  <= divisor_next;
            div_zero_reg <= div_zero_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, datapath and ALU drive
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        mcand_next    = mcand_reg;
        divisor_next  = divisor_reg;
        div_zero_next = div_zero_reg;
        // Idle ALU request: harmless add of zeros.
        alu_control   = ALU_ADD;
        alu_operand_1 = '0;
        alu_operand_2 = '0;

        case (state_reg)
            SEQ_IDLE: begin
                if (start) begin
                    mcand_next    = operand_a;
                    divisor_next  = operand_b;
                    count_next    = '0;
                    div_zero_next = 1'b0;
                    if (op == OP_MULTU) begin
                        hi_next    = '0;
                        lo_next    = operand_b;
                        state_next = SEQ_MUL;
                    end else if (operand_b != 32'd0) begin
                        hi_next    = '0;
                        lo_next    = operand_a;
                        state_next = SEQ_DIV;
                    end else begin
                        {hi_next, lo_next} = div_by_zero_result(operand_a);
                        div_zero_next      = 1'b1;
                        state_next         = SEQ_DONE;
                    end
                end
            end

            SEQ_MUL: begin
                // Shift-add: conditionally add the multiplicand into hi, then
                // shift {carry, sum, lo} right one bit. The multiplier bits
                // drain out of lo as product bits enter from the top.
                alu_control   = ALU_ADD;
                alu_operand_1 = hi_reg;
                alu_operand_2 = lo_reg[0] ? mcand_reg : 32'd0;
                hi_next       = {alu_carry, alu_result[31:1]};
                lo_next       = {alu_result[0], lo_reg[31:1]};
                count_next    = count_reg + 1'b1;
                if (count_reg == SEQ_LAST_COUNT) begin
                    state_next = SEQ_DONE;
                end
            end

            SEQ_DIV: begin
                // Restoring division: trial-subtract the divisor from the
                // shifted partial remainder; keep the difference only when the
                // quotient bit is 1. Quotient bits enter lo from the bottom as
                // dividend bits leave from the top.
                alu_control   = ALU_SUB;
                alu_operand_1 = div_shifted;
                alu_operand_2 = divisor_reg;
                hi_next       = div_q ? alu_result : div_shifted;
                lo_next       = {lo_reg[30:0], div_q};
                count_next    = count_reg + 1'b1;
                if (count_reg == SEQ_LAST_COUNT) begin
                    state_next = SEQ_DONE;
                end
            end

            SEQ_DONE: begin
                state_next = SEQ_IDLE;
            end

            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != SEQ_IDLE);
    assign done     = (state_reg == SEQ_DONE);
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign div_zero = div_zero_reg;

endmodule : alu_muldiv_sequencer

// File: tb/tb_alu_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_sequencer
// Self-checking bench for alu_muldiv_sequencer. A behavioural ALU supplies the
// add/subtract results; expected hi/lo/div_zero come from plain 64-bit
// multiply, divide and modulo. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic [3:0]  alu_control;
    logic [31:0] alu_operand_1;
    logic [31:0] alu_operand_2;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .busy          (busy),
        .done          (done),
        .hi            (hi),
        .lo            (lo),
        .div_zero      (div_zero),
        .alu_control   (alu_control),
        .alu_operand_1 (alu_operand_1),
        .alu_operand_2 (alu_operand_2),
        .alu_result    (alu_result),
        .alu_status    (alu_status)
    );

    // Behavioural shared ALU: add reports carry-out, subtract reports borrow
    // on status bit 5.
    always_comb begin
        logic [32:0] sum;
        logic        c;
        sum        = '0;
        c          = 1'b0;
        alu_result = '0;
        case (alu_control)
            4'b0010: begin
                sum        = {1'b0, alu_operand_1} + {1'b0, alu_operand_2};
                alu_result = sum[31:0];
                c          = sum[32];
            end
            4'b0110: begin
                alu_result = alu_operand_1 - alu_operand_2;
                c          = (alu_operand_1 < alu_operand_2);
            end
            4'b0000: alu_result = alu_operand_1 & alu_operand_2;
            4'b0001: alu_result = alu_operand_1 | alu_operand_2;
            default: alu_result = '0;
        endcase
        alu_status    = '0;
        alu_status[5] = c;
        alu_status[7] = (alu_result == 32'd0);
    end

    // Reference: {div_zero, hi, lo}.
    function automatic logic [64:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!o) begin
            p = 64'(a) * 64'(b);
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
    endfunction

    function automatic int ref_latency(input logic o, input logic [31:0] b);
        return (o && b == 32'd0) ? 1 : 33;
    endfunction

    // Drives one request starting in the current (IDLE) cycle and collects the
    // observations: cycles from start to done, result, busy violations while
    // running, and busy/done in the cycle after done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [64:0] res, output int busy_bad,
                          output logic post_busy, output logic post_done);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        // Scramble inputs to show they are only sampled at acceptance.
        start = 1'b0; op = 1'($urandom); operand_a = $urandom; operand_b = $urandom;
        lat = -1; busy_bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        res = {div_zero, hi, lo};
        @(negedge clk);
        post_busy = busy;
        post_done = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        #2;
        n_checks++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, div_zero, hi, lo);
        end
        n_checks++;
        if ({alu_control, alu_operand_1, alu_operand_2} !== {4'b0010, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_alu: got ctl=%b op1=%h op2=%h, want 0010/0/0", alu_control, alu_operand_1, alu_operand_2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        $display("test_reset done");
    endtask

    // Directed cases with the same checks on each.
    task automatic test_directed(input string name, input logic o, input logic [31:0] a, input logic [31:0] b);
        int lat, bb; logic [64:0] res, exp_res; logic pb, pd;
        exp_res = ref_result(o, a, b);
        run_op(o, a, b, lat, res, bb, pb, pd);
        n_checks++;
        if (lat != ref_latency(o, b)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, want %0d", name, lat, ref_latency(o, b));
        end
        n_checks++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got dz=%b hi=%h lo=%h, want dz=%b hi=%h lo=%h",
                     name, res[64], res[63:32], res[31:0], exp_res[64], exp_res[63:32], exp_res[31:0]);
        end
        n_checks++;
        if (bb != 0 || pb !== 1'b0 || pd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_done_window: got busy_bad=%0d post_busy=%b post_done=%b, want 0 0 0", name, bb, pb, pd);
        end
        $display("%s: op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h dz=%b", name, o, a, b, lat, res[63:32], res[31:0], res[64]);
    endtask

    task automatic test_mul();
        test_directed("mul_3x5",      1'b0, 32'd3, 32'd5);
        test_directed("mul_max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        test_directed("mul_zero",     1'b0, 32'h12345678, 32'd0);
    endtask

    task automatic test_div();
        test_directed("div_100_7",    1'b1, 32'd100, 32'd7);
        test_directed("div_big",      1'b1, 32'hFFFFFFFF, 32'h80000001);
        test_directed("div_msb_path", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        test_directed("div_by_one",   1'b1, 32'hA5A5A5A5, 32'd1);
    endtask

    task automatic test_div_zero();
        test_directed("div_zero",     1'b1, 32'd1234, 32'd0);
        // A following normal divide must clear the flag.
        test_directed("div_after_zero", 1'b1, 32'd50, 32'd5);
    endtask

    // A start pulse while busy must not disturb the running operation.
    task automatic test_ignore_start();
        int lat;
        start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 1'b1; operand_a = 32'd1000; operand_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd15) begin
            n_fail++;
            $display("FAIL ignore_start: got lat=%0d hi=%h lo=%h, want 33 0 0000000f", lat, hi, lo);
        end
        // Start during the DONE cycle is ignored too.
        start = 1'b1; op = 1'b1; operand_a = 32'd9; operand_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || div_zero !== 1'b0 || lo !== 32'd15) begin
            n_fail++;
            $display("FAIL ignore_start_done: got busy=%b dz=%b lo=%h, want 0 0 0000000f", busy, div_zero, lo);
        end
        $display("test_ignore_start: lat=%0d hi=%h lo=%h", lat, hi, lo);
    endtask

    // Reset mid-operation aborts with no done pulse; the next start works.
    task automatic test_reset_abort();
        int seen_done;
        start = 1'b1; op = 1'b1; operand_a = 32'hDEADBEEF; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0 ||
            {alu_control, alu_operand_1, alu_operand_2} !== {4'b0010, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_abort_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h ctl=%b, want all 0 ctl=0010",
                     busy, done, div_zero, hi, lo, alu_control);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: got %0d busy/done cycles after reset, want 0", seen_done);
        end
        $display("test_reset_abort: quiet cycles checked");
        test_directed("after_reset", 1'b1, 32'hDEADBEEF, 32'd7);
    endtask

    // Consecutive operations, each started in the first IDLE cycle.
    task automatic test_back_to_back();
        int lat, bb, t0; logic [64:0] res, exp_res; logic pb, pd;
        logic [31:0] a, b;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom | 32'd1;
            exp_res = ref_result(i[0], a, b);
            run_op(i[0], a, b, lat, res, bb, pb, pd);
            n_checks++;
            if (res !== exp_res || lat != 33) begin
                n_fail++;
                $display("FAIL b2b_%0d: got lat=%0d hi=%h lo=%h, want 33 %h %h", i, lat, res[63:32], res[31:0], exp_res[63:32], exp_res[31:0]);
            end
            $display("b2b_%0d: op=%0d a=%h b=%h hi=%h lo=%h", i, i[0], a, b, res[63:32], res[31:0]);
        end
        n_checks++;
        if (cyc - t0 != 102) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d cycles, want 102", cyc - t0);
        end
    endtask

    task automatic test_random();
        int lat, bb; logic [64:0] res, exp_res; logic pb, pd;
        logic o; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            exp_res = ref_result(o, a, b);
            run_op(o, a, b, lat, res, bb, pb, pd);
            n_checks++;
            if (res !== exp_res || lat != ref_latency(o, b) || bb != 0 || pb !== 1'b0 || pd !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_%0d: op=%0d a=%h b=%h got lat=%0d dz=%b hi=%h lo=%h, want lat=%0d dz=%b hi=%h lo=%h",
                         i, o, a, b, lat, res[64], res[63:32], res[31:0],
                         ref_latency(o, b), exp_res[64], exp_res[63:32], exp_res[31:0]);
            end
            $display("rand_%0d: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b", i, o, a, b, res[63:32], res[31:0], res[64]);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_muldiv_sequencer
